if_buf_writer: RTL



---
 rtl/if_buf_writer_pkg.sv | 14 +
 rtl/if_buf_writer_skid.sv | 48 ++++
 rtl/if_buf_writer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/if_buf_writer_pkg.sv
// Shared definitions for the IF buffer writer: flag bit positions above the data word and FSM encoding.
package if_buf_writer_pkg;

    localparam int unsigned EOR_BIT = 0;
    localparam int unsigned EOF_BIT = 1;
    localparam int unsigned FLAG_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/if_buf_writer_skid.sv
// Two-entry skid FIFO between memory read data and the IF buffer; head is the oldest entry.
module if_buf_writer_skid
    import if_buf_writer_pkg::*;
#(
    parameter int unsigned WIDTH = 8 + FLAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) head <= push_data;
                    else             tail <= push_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                // Arrival and pop together keep occupancy; data shifts toward the head.
                2'b11: begin
                    if (occ == 2'd1) begin
                        head <= push_data;
                    end else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/if_buf_writer.sv
// Fetches a 2-D feature-map tile row by row and pushes {eof, eor, data} words into the IF buffer.
// Optional stall counter output enabled by defining IF_BUF_WRITER_STALL_CNT_EN.
module if_buf_writer
    import if_buf_writer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned MEM_ADDR_LEN = 16,
    parameter int unsigned DIM_LEN      = 8
) (
`ifdef IF_BUF_WRITER_STALL_CNT_EN
    output logic [31:0]               stall_cycles,
`endif
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [MEM_ADDR_LEN-1:0]   base_addr,
    input  logic [DIM_LEN-1:0]        row_len,
    input  logic [DIM_LEN-1:0]        row_count,
    input  logic [DIM_LEN-1:0]        row_pitch,
    output logic                      mem_ren,
    output logic [MEM_ADDR_LEN-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    input  logic                      IF_buf_full,
    output logic                      IF_buf_write,
    output logic [DATA_WIDTH+1:0]     IF_buf_outval,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned OUT_W = DATA_WIDTH + FLAG_W;

    state_t                  state;
    logic [MEM_ADDR_LEN-1:0] row_base;
    logic [DIM_LEN-1:0]      col;
    logic [DIM_LEN-1:0]      row;
    logic [DIM_LEN-1:0]      len_q;
    logic [DIM_LEN-1:0]      cnt_q;
    logic [DIM_LEN-1:0]      pitch_q;
    logic                    inflight;
    logic [FLAG_W-1:0]       flags_q;
    logic [FLAG_W-1:0]       issue_flags;
    logic                    last_col;
    logic                    last_row;
    logic [1:0]              occ;
    logic [2:0]              pending;

    // pending is the skid occupancy plus in-flight read as it will stand next cycle.
    always_comb begin
        last_col     = (col == len_q - DIM_LEN'(1));
        last_row     = (row == cnt_q - DIM_LEN'(1));
        issue_flags  = '0;
        issue_flags[EOR_BIT] = last_col;
        issue_flags[EOF_BIT] = last_col && last_row;
        IF_buf_write = (occ != 2'd0) && !IF_buf_full;
        pending      = 3'(occ) + 3'(inflight) - 3'(IF_buf_write);
        mem_ren      = (state == ST_RUN) && (pending < 3'd2);
        mem_addr     = row_base + MEM_ADDR_LEN'(col);
    end

    if_buf_writer_skid #(.WIDTH(OUT_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data ({flags_q, mem_rdata}),
        .pop       (IF_buf_write),
        .head      (IF_buf_outval),
        .occ       (occ)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            row_base <= '0;
            col      <= '0;
            row      <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            pitch_q  <= '0;
            inflight <= 1'b0;
            flags_q  <= '0;
        end else begin
            done     <= 1'b0;
            inflight <= mem_ren;
            if (mem_ren) flags_q <= issue_flags;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        row_base <= base_addr;
                        col      <= '0;
                        row      <= '0;
                        len_q    <= row_len;
                        cnt_q    <= row_count;
                        pitch_q  <= row_pitch;
                        if (row_len == '0 || row_count == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (mem_ren) begin
                        if (last_col) begin
                            col      <= '0;
                            row      <= row + DIM_LEN'(1);
                            row_base <= row_base + MEM_ADDR_LEN'(pitch_q);
                        end else begin
                            col <= col + DIM_LEN'(1);
                        end
                        if (last_col && last_row) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pending == 3'd0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef IF_BUF_WRITER_STALL_CNT_EN
    // Cycles where the skid holds data but the IF buffer refuses it; saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (state == ST_IDLE && start) begin
            stall_cycles <= '0;
        end else if (occ != 2'd0 && IF_buf_full && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule
